// File: rtl/adpll_cfg_pkg.sv
// adpll_cfg_pkg: shared state encoding, default timing and width constants for the ADPLL config loader.
package adpll_cfg_pkg;
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SETUP, S_PULSE, S_HOLD, S_DONE} state_t;
   localparam int SEL_W         = 3;
   localparam int DEF_N_PARAM   = 8;
   localparam int DEF_VAL_W     = 5;
   localparam int DEF_CLR_CYC   = 4;
   localparam int DEF_SETUP_CYC = 2;
   localparam int DEF_PULSE_CYC = 4;
   localparam int DEF_HOLD_CYC  = 2;
   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = (a > b) ? a : b;
      m = (c > m) ? c : m;
      return (d > m) ? d : m;
   endfunction
endpackage

// File: rtl/adpll_cfg_loader_if.sv
// adpll_cfg_loader_if: shadow-table write port, sequence control and ADPLL programming outputs.
interface adpll_cfg_loader_if import adpll_cfg_pkg::*; #(parameter int VAL_W = DEF_VAL_W);
   logic             i_wr_en;
   logic [SEL_W-1:0] i_wr_addr;
   logic [VAL_W-1:0] i_wr_data;
   logic             i_inv_all;
   logic             i_start;
   logic             i_abort;
   logic             o_clr;
   logic             o_program;
   logic [SEL_W-1:0] o_param_sel;
   logic [VAL_W-1:0] o_pgm_value;
   logic             o_busy;
   logic             o_done;
   logic             o_wr_err;
   modport slave (input i_wr_en, i_wr_addr, i_wr_data, i_inv_all, i_start, i_abort,
                  output o_clr, o_program, o_param_sel, o_pgm_value, o_busy, o_done, o_wr_err);
   modport master (output i_wr_en, i_wr_addr, i_wr_data, i_inv_all, i_start, i_abort,
                   input o_clr, o_program, o_param_sel, o_pgm_value, o_busy, o_done, o_wr_err);
endinterface

// File: rtl/adpll_cfg_timer.sv
// adpll_cfg_timer: phase down-counter, loaded on state entry, flags zero when the phase ends.
module adpll_cfg_timer #(parameter int W = 3) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_zero
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else if (i_load) r_cnt <= i_value;
      else if (!o_zero) r_cnt <= r_cnt - 1'b1;
   assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/adpll_cfg_loader.sv
// adpll_cfg_loader: shadow table of ADPLL parameters, replayed as clear/setup/pulse/hold sequences.
module adpll_cfg_loader import adpll_cfg_pkg::*; #(
   parameter int N_PARAM   = DEF_N_PARAM,
   parameter int VAL_W     = DEF_VAL_W,
   parameter int CLR_CYC   = DEF_CLR_CYC,
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int PULSE_CYC = DEF_PULSE_CYC,
   parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
   input logic clk,
   input logic rst_n,
   adpll_cfg_loader_if.slave bus
);
   localparam int CW = $clog2(max4(CLR_CYC, SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
   state_t           r_state;
   logic [VAL_W-1:0] r_data [N_PARAM];
   logic [N_PARAM-1:0] r_valid;
   logic             r_clr, r_prog, r_busy, r_done, r_wr_err;
   logic [SEL_W-1:0] r_sel;
   logic [VAL_W-1:0] r_val;
   logic             w_load, w_zero, w_found;
   logic [CW-1:0]    w_value;
   logic [SEL_W-1:0] w_idx;
   int               w_from;
   adpll_cfg_timer #(.W(CW)) u_timer (.clk(clk), .rst_n(rst_n), .i_load(w_load), .i_value(w_value), .o_zero(w_zero));
   // Table is frozen while busy, so it doubles as the snapshot taken at start.
   always_ff @(posedge clk)
      if (bus.i_wr_en && !r_busy) r_data[bus.i_wr_addr] <= bus.i_wr_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_valid  <= '0;
         r_wr_err <= 1'b0;
      end else begin
         r_wr_err <= (bus.i_wr_en || bus.i_inv_all) && r_busy;
         if (!r_busy && bus.i_inv_all) r_valid <= '0;
         if (!r_busy && bus.i_wr_en) r_valid[bus.i_wr_addr] <= 1'b1;
      end
   // Invalid entries are skipped combinationally, so they cost no cycles.
   always_comb begin
      w_from  = (r_state == S_HOLD) ? int'(r_sel) + 1 : 0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int i = N_PARAM - 1; i >= 0; i--)
         if (r_valid[i] && i >= w_from) begin
            w_found = 1'b1;
            w_idx   = SEL_W'(i);
         end
      w_load  = (r_state == S_IDLE) ? bus.i_start : w_zero;
      w_value = (r_state == S_IDLE)  ? CW'(CLR_CYC - 1) :
                (r_state == S_SETUP) ? CW'(PULSE_CYC - 1) :
                (r_state == S_PULSE) ? CW'(HOLD_CYC - 1) : CW'(SETUP_CYC - 1);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_clr   <= 1'b0;
         r_prog  <= 1'b0;
         r_sel   <= '0;
         r_val   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.i_abort && r_busy) begin
            r_state <= S_IDLE;
            r_clr   <= 1'b0;
            r_prog  <= 1'b0;
            r_busy  <= 1'b0;
         end else case (r_state)
            S_IDLE: if (bus.i_start && !bus.i_abort) begin
               r_state <= S_CLEAR;
               r_clr   <= 1'b1;
               r_busy  <= 1'b1;
            end
            S_CLEAR, S_HOLD: if (w_zero) begin
               r_clr <= 1'b0;
               if (w_found) begin
                  r_state <= S_SETUP;
                  r_sel   <= w_idx;
                  r_val   <= r_data[w_idx];
               end else begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_SETUP: if (w_zero) begin
               r_state <= S_PULSE;
               r_prog  <= 1'b1;
            end
            S_PULSE: if (w_zero) begin
               r_state <= S_HOLD;
               r_prog  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   assign bus.o_clr       = r_clr;
   assign bus.o_program   = r_prog;
   assign bus.o_param_sel = r_sel;
   assign bus.o_pgm_value = r_val;
   assign bus.o_busy      = r_busy;
   assign bus.o_done      = r_done;
   assign bus.o_wr_err    = r_wr_err;
endmodule
